gpio_in: RTL and testbench
==========================

// Module: gpio_in
// PURPOSE
// - Memory-mapped GPIO input port: the read side of the board pin interface, complementing the output GPIO.
// - Samples N_PINS external pins, synchronises and debounces them, and latches sticky rising-edge flags.
// - Sits on the CPU data bus beside RAM; decodes alu_out-style addresses and returns read data combinationally.
// - Single-cycle core: read data is valid in the same cycle as the address; updates commit on the CLK edge.
// PARAMETERS
// - N_PINS      4           number of input pins (1..32)
// - BASE_ADDR   32'h0000_1000  word-aligned base of the 16-byte register window
// - DEB_CYCLES  16'd50000   consecutive stable cycles needed to accept a new pin level (>=1)
// PORTS
// - CLK        in   1          system clock
// - reset      in   1          asynchronous, active-low reset
// - pins_in    in   N_PINS     raw asynchronous board pins
// - addr       in   `WORDSIZE  byte address from the ALU
// - wdata      in   `WORDSIZE  store data (from rs2)
// - we         in   1          store strobe (ctrl_memwrite)
// - hit        out  1          addr lies in [BASE_ADDR, BASE_ADDR+16); combinational
// - rdata      out  `WORDSIZE  read data; combinational; 0 when !hit
// BEHAVIOUR
// - Register map (offset, bits [3:2] decoded, [1:0] ignored):
//   0x0 DATA  RO  debounced pin levels in [N_PINS-1:0], upper bits 0
//   0x4 RISE  W1C sticky rising-edge flags per pin
//   0x8 FALL  W1C sticky falling-edge flags (GPIOIN_FALL_EDGE_EN only, else reads 0, writes ignored)
//   0xC ECNT  16-bit edge-event counter in [15:0]; any write with hit clears it to 0
// - Reset (reset==0, async): sync flops, stable levels, debounce counters, RISE, FALL, ECNT all 0.
//   hit/rdata are combinational and need no reset value.
// - Sync: per-pin 2-flop synchroniser; a pin change reaches the debouncer 2 cycles later.
// - Debounce per pin: cnt counts while sync != stable; cnt resets to 0 whenever sync == stable;
//   when cnt reaches DEB_CYCLES-1 while still differing, stable <= sync and cnt <= 0.
//   Total latency pin -> DATA = 2 + DEB_CYCLES cycles. A glitch shorter than DEB_CYCLES never shows.
// - Edge detect: a pin's rise is stable 0->1 in this cycle. RISE[i] <= 1 on rise; cleared when
//   we && hit && offset==0x4 && wdata[i]. Set and clear in the same cycle: set wins.
// - ECNT increments by exactly 1 in any cycle where at least one pin rises (or falls when
//   GPIOIN_FALL_EDGE_EN is defined), regardless of how many pins change. It saturates at 16'hFFFF.
//   A write clear in the same cycle as an event leaves ECNT = 1.
// - Writes to DATA are ignored. Accesses with !hit have no effect and give rdata = 0.
// - Reset asserted mid-debounce discards the partial count; after reset release DATA = 0 until each
//   high pin has been stable for DEB_CYCLES.
// CONFIGURATION
// - GPIOIN_FALL_EDGE_EN defined: FALL register is implemented with the same set-wins W1C rules as RISE,
//   and falls count toward ECNT.
// - GPIOIN_FALL_EDGE_EN undefined: no FALL flops; offset 0x8 reads 0; ECNT counts rises only.
// STRUCTURE
// - defs.v gains `GPIOIN_OFF_DATA 2'd0, `GPIOIN_OFF_RISE 2'd1, `GPIOIN_OFF_FALL 2'd2, `GPIOIN_OFF_ECNT 2'd3
//   (addr[3:2] codes) and `GPIOIN_ECNT_W 16. `WORDSIZE is reused.
// - Sub-module gpio_in_debounce (one pin: synchroniser + counter + stable flop), generated N_PINS times.
// - gpio_in holds address decode, edge logic, RISE/FALL/ECNT and the read mux.
// TESTING (DEB_CYCLES=4, N_PINS=4, BASE_ADDR=32'h1000)
// - Reset: drive pins=4'hF during reset=0, read 0x1000/0x1004/0x100C -> all 0. After release, DATA=4'hF at cycle 6.
// - Glitch: pin0 high for 3 cycles then low -> DATA stays 0, RISE stays 0, ECNT stays 0.
// - Rise: pin2 0->1 held -> DATA=4'h4 after 6 cycles, RISE=4'h4, ECNT=1. Write 0x1004 with 4'h4 -> RISE=0.
// - Set-wins: write RISE W1C 4'h1 in the same cycle pin0's rise commits -> RISE[0]=1 afterwards.
// - Counter: pins 1 and 3 rise in the same cycle -> ECNT +1 only. Preload to 16'hFFFF and rise again -> stays FFFF.
//   Any write to 0x100C -> 0.
// - Decode/config: read 0x2000 -> hit=0, rdata=0. With GPIOIN_FALL_EDGE_EN, pin1 1->0 -> FALL=4'h2.
//   Without it, 0x1008 reads 0.

Source files
------------

// File: rtl/gpio_in_pkg.sv
// gpio_in_pkg: shared widths, register offset codes and helpers for the
// memory-mapped GPIO input port.
//   GPIOIN_WORDSIZE  CPU data/address bus width
//   GPIOIN_ECNT_W    width of the edge-event counter
//   GPIOIN_DEB_W     width of the per-pin debounce counter
//   gpioin_off_e     register codes taken from address offset bits [3:2]
package gpio_in_pkg;

  localparam int GPIOIN_WORDSIZE = 32;
  localparam int GPIOIN_ECNT_W   = 16;
  localparam int GPIOIN_DEB_W    = 16;

  typedef enum logic [1:0] {
    GPIOIN_OFF_DATA = 2'd0,
    GPIOIN_OFF_RISE = 2'd1,
    GPIOIN_OFF_FALL = 2'd2,
    GPIOIN_OFF_ECNT = 2'd3
  } gpioin_off_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [GPIOIN_ECNT_W-1:0] ecnt_sat_inc(
    input logic [GPIOIN_ECNT_W-1:0] v
  );
    return (v == '1) ? v : v + GPIOIN_ECNT_W'(1);
  endfunction

endpackage

// File: rtl/gpio_in_if.sv
// gpio_in_if: CPU data-bus view of the GPIO input register window.
//   addr   byte address from the ALU          (master -> slave)
//   wdata  store data                         (master -> slave)
//   we     store strobe                       (master -> slave)
//   hit    address lies in the register window, combinational (slave -> master)
//   rdata  read data, combinational, 0 on miss (slave -> master)
interface gpio_in_if;
  import gpio_in_pkg::*;

  logic [GPIOIN_WORDSIZE-1:0] addr;
  logic [GPIOIN_WORDSIZE-1:0] wdata;
  logic                       we;
  logic                       hit;
  logic [GPIOIN_WORDSIZE-1:0] rdata;

  modport master (output addr, output wdata, output we, input hit, input rdata);
  modport slave  (input addr, input wdata, input we, output hit, output rdata);

endinterface

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: one pin of the GPIO input port.
// Two-flop synchroniser followed by a stability counter; the accepted level
// only moves after the synchronised pin has disagreed with it for DEB_CYCLES
// consecutive cycles.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_pin    raw asynchronous board pin
//   o_level  debounced (accepted) level
//   o_rise   high in the cycle whose clock edge commits a 0->1 change
//   o_fall   high in the cycle whose clock edge commits a 1->0 change
module gpio_in_debounce
  import gpio_in_pkg::*;
#(
  parameter logic [GPIOIN_DEB_W-1:0] DEB_CYCLES = 16'd50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_stable;
  logic [GPIOIN_DEB_W-1:0] r_cnt;

  logic w_differs;
  logic w_commit;

  assign w_differs = (r_sync2 != r_stable);
  // r_cnt counts the earlier differing cycles, so the current one is the
  // DEB_CYCLES-th when r_cnt has reached DEB_CYCLES-1.
  assign w_commit  = w_differs && (r_cnt == DEB_CYCLES - GPIOIN_DEB_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + GPIOIN_DEB_W'(1);
      end
    end
  end

  assign o_level = r_stable;
  assign o_rise  = w_commit &  r_sync2;
  assign o_fall  = w_commit & ~r_sync2;

endmodule

// File: rtl/gpio_in.sv
// gpio_in: memory-mapped GPIO input port on the CPU data bus.
// Debounces N_PINS board pins, keeps sticky write-1-to-clear edge flags and a
// saturating edge-event counter, and returns read data combinationally.
//   CLK      system clock
//   reset    asynchronous active-low reset
//   pins_in  raw asynchronous board pins
//   bus      gpio_in_if slave: addr/wdata/we in, hit/rdata out
// Register window at BASE_ADDR (offset bits [3:2]):
//   0x0 DATA (RO), 0x4 RISE (W1C), 0x8 FALL (W1C), 0xC ECNT (any write clears)
// Build option: GPIOIN_FALL_EDGE_EN implements FALL and counts falls in ECNT;
// without it offset 0x8 reads 0 and only rises are counted.
module gpio_in
  import gpio_in_pkg::*;
#(
  parameter int                          N_PINS     = 4,
  parameter logic [GPIOIN_WORDSIZE-1:0]  BASE_ADDR  = 32'h0000_1000,
  parameter logic [GPIOIN_DEB_W-1:0]     DEB_CYCLES = 16'd50000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [N_PINS-1:0] pins_in,
  gpio_in_if.slave          bus
);

  logic [GPIOIN_WORDSIZE-1:0] w_delta;
  logic                       w_hit;
  gpioin_off_e                w_off;
  logic                       w_wr;

  logic [N_PINS-1:0] w_level;
  logic [N_PINS-1:0] w_rise_p;
  logic [N_PINS-1:0] w_fall_p;
  logic [N_PINS-1:0] w_rise_clr;
  logic              w_event;
  logic              w_ecnt_clr;

  logic [N_PINS-1:0]        r_rise;
  logic [GPIOIN_ECNT_W-1:0] r_ecnt;

  logic [GPIOIN_WORDSIZE-1:0] w_rdata;
  logic                       w_unused;

  // Window check by subtraction so BASE_ADDR only needs word alignment.
  assign w_delta = bus.addr - BASE_ADDR;
  assign w_hit   = (bus.addr >= BASE_ADDR) && (w_delta < GPIOIN_WORDSIZE'(16));
  assign w_off   = gpioin_off_e'(w_delta[3:2]);
  assign w_wr    = bus.we && w_hit;

  for (genvar g = 0; g < N_PINS; g++) begin : g_pin
    gpio_in_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .i_clk   (CLK),
      .i_rst_n (reset),
      .i_pin   (pins_in[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise_p[g]),
      .o_fall  (w_fall_p[g])
    );
  end

  assign w_rise_clr = (w_wr && (w_off == GPIOIN_OFF_RISE)) ? bus.wdata[N_PINS-1:0] : '0;
  assign w_ecnt_clr = w_wr && (w_off == GPIOIN_OFF_ECNT);

  // New edges are OR-ed in after the clear so a same-cycle set survives.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_rise <= '0;
    end else begin
      r_rise <= (r_rise & ~w_rise_clr) | w_rise_p;
    end
  end

`ifdef GPIOIN_FALL_EDGE_EN
  logic [N_PINS-1:0] w_fall_clr;
  logic [N_PINS-1:0] r_fall;

  assign w_fall_clr = (w_wr && (w_off == GPIOIN_OFF_FALL)) ? bus.wdata[N_PINS-1:0] : '0;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_fall <= '0;
    end else begin
      r_fall <= (r_fall & ~w_fall_clr) | w_fall_p;
    end
  end

  assign w_event  = (|w_rise_p) | (|w_fall_p);
  assign w_unused = ^{bus.wdata, w_delta[GPIOIN_WORDSIZE-1:4], w_delta[1:0]};
`else
  assign w_event  = |w_rise_p;
  assign w_unused = ^{bus.wdata, w_delta[GPIOIN_WORDSIZE-1:4], w_delta[1:0], w_fall_p};
`endif

  // One count per cycle with any edge, however many pins moved. A clear that
  // coincides with an event leaves that event counted.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_ecnt <= '0;
    end else if (w_ecnt_clr) begin
      r_ecnt <= GPIOIN_ECNT_W'(w_event);
    end else if (w_event) begin
      r_ecnt <= ecnt_sat_inc(r_ecnt);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_off)
        GPIOIN_OFF_DATA: w_rdata[N_PINS-1:0] = w_level;
        GPIOIN_OFF_RISE: w_rdata[N_PINS-1:0] = r_rise;
`ifdef GPIOIN_FALL_EDGE_EN
        GPIOIN_OFF_FALL: w_rdata[N_PINS-1:0] = r_fall;
`else
        GPIOIN_OFF_FALL: w_rdata = '0;
`endif
        GPIOIN_OFF_ECNT: w_rdata[GPIOIN_ECNT_W-1:0] = r_ecnt;
        default:         w_rdata = '0;
      endcase
    end
  end

  assign bus.hit   = w_hit;
  assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_gpio_in.sv
module tb_gpio_in;
  import gpio_in_pkg::*;

  localparam int          NP   = 4;
  localparam int          DEB  = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [NP-1:0] pins  = '0;

  gpio_in_if bus ();

  gpio_in #(
    .N_PINS     (NP),
    .BASE_ADDR  (BASE),
    .DEB_CYCLES (16'(DEB))
  ) dut (
    .CLK     (clk),
    .reset   (rst_n),
    .pins_in (pins),
    .bus     (bus)
  );

  always #50 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a pin level is accepted once the last DEB synchronised
  // samples (pin value two edges back and older) all disagree with it.
  logic [NP-1:0] hist [0:DEB+1];
  logic [NP-1:0] m_data;
  logic [NP-1:0] m_rise;
  logic [NP-1:0] m_fall;
  logic [15:0]   m_ecnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] idx;
    if (!m_hit(a)) return 32'd0;
    idx = (a - BASE) / 4;
    case (idx)
      0: return {28'd0, m_data};
      1: return {28'd0, m_rise};
`ifdef GPIOIN_FALL_EDGE_EN
      2: return {28'd0, m_fall};
`else
      2: return 32'd0;
`endif
      3: return {16'd0, m_ecnt};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int j = 0; j <= DEB + 1; j++) hist[j] = '0;
    m_data = '0;
    m_rise = '0;
    m_fall = '0;
    m_ecnt = '0;
  endtask

  task automatic model_edge();
    logic [NP-1:0] nxt, rise, fall, clr_r, clr_f;
    logic          all_diff, wr, ev;
    logic [31:0]   idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = pins;
    nxt = m_data;
    for (int i = 0; i < NP; i++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DEB + 1; j++)
        if (hist[j][i] == m_data[i]) all_diff = 1'b0;
      if (all_diff) nxt[i] = ~m_data[i];
    end
    rise  = nxt & ~m_data;
    fall  = ~nxt & m_data;
    wr    = bus.we && m_hit(bus.addr);
    idx   = (bus.addr - BASE) / 4;
    clr_r = (wr && idx == 1) ? bus.wdata[NP-1:0] : '0;
    clr_f = (wr && idx == 2) ? bus.wdata[NP-1:0] : '0;
    m_rise = (m_rise & ~clr_r) | rise;
`ifdef GPIOIN_FALL_EDGE_EN
    m_fall = (m_fall & ~clr_f) | fall;
    ev = (rise != 0) || (fall != 0);
`else
    m_fall = '0;
    ev = (rise != 0);
`endif
    if (wr && idx == 3) m_ecnt = ev ? 16'd1 : 16'd0;
    else if (ev && m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
    m_data = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] a_save;
    a_save = bus.addr;
    for (int k = 0; k < 4; k++) begin
      bus.addr = BASE + 32'(4 * k);
      #1;
      check($sformatf("%s_off%0h", tag, 4 * k), bus.rdata, m_read(bus.addr));
    end
    bus.addr = a_save;
  endtask

  task automatic ticks(input int n, input string tag);
    repeat (n) begin
      tick();
      check_regs(tag);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
    bus.wdata = '0;
    check_regs(tag);
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic chk_hit(input string tag, input logic [31:0] a, input logic exp);
    bus.addr = a;
    #1;
    check(tag, {31'd0, bus.hit}, {31'd0, exp});
  endtask

  initial begin
    logic [31:0] ra;
    int          hold;
    int          sel;

    bus.addr  = BASE;
    bus.wdata = '0;
    bus.we    = 1'b0;
    pins      = 4'hF;
    model_reset();
    #1 rst_n = 1'b0;

    // Reset with all pins high
    chk_rd("rst_data", BASE + 32'h0, 32'h0);
    chk_rd("rst_rise", BASE + 32'h4, 32'h0);
    chk_rd("rst_ecnt", BASE + 32'hC, 32'h0);
    ticks(2, "in_rst");
    rst_n = 1'b1;
    ticks(5, "rel");
    chk_rd("rel_data_c5", BASE, 32'h0);
    ticks(1, "rel6");
    chk_rd("rel_data_c6", BASE, 32'hF);
    chk_rd("rel_ecnt", BASE + 32'hC, 32'h1);
    chk_rd("rel_rise", BASE + 32'h4, 32'hF);
    bus_write(BASE + 32'hC, 32'h0, "clr_ecnt");
    chk_rd("clr_ecnt", BASE + 32'hC, 32'h0);
    bus_write(BASE + 32'h4, 32'hF, "clr_rise");
    chk_rd("clr_rise", BASE + 32'h4, 32'h0);
    pins = 4'h0;
    ticks(8, "all_low");
    bus_write(BASE + 32'hC, 32'h0, "clr_ecnt2");
    bus_write(BASE + 32'h8, 32'hF, "clr_fall");

    // Glitch of 3 cycles on pin0
    pins = 4'h1;
    ticks(3, "glitch");
    pins = 4'h0;
    ticks(10, "glitch_after");
    chk_rd("glitch_data", BASE, 32'h0);
    chk_rd("glitch_rise", BASE + 32'h4, 32'h0);
    chk_rd("glitch_ecnt", BASE + 32'hC, 32'h0);

    // Single rise on pin2
    pins = 4'h4;
    ticks(5, "rise2");
    chk_rd("rise2_data_c5", BASE, 32'h0);
    ticks(1, "rise2_c6");
    chk_rd("rise2_data", BASE, 32'h4);
    chk_rd("rise2_rise", BASE + 32'h4, 32'h4);
    chk_rd("rise2_ecnt", BASE + 32'hC, 32'h1);
    bus_write(BASE + 32'h4, 32'h4, "rise2_w1c");
    chk_rd("rise2_w1c", BASE + 32'h4, 32'h0);

    // W1C in the very cycle pin0's rise commits: set wins
    pins = 4'h5;
    ticks(5, "setwin");
    bus_write(BASE + 32'h4, 32'h1, "setwin_wr");
    chk_rd("setwin_rise", BASE + 32'h4, 32'h1);
    chk_rd("setwin_ecnt", BASE + 32'hC, 32'h2);

    // ECNT clear coinciding with an event
    pins = 4'h7;
    ticks(5, "clrev");
    bus_write(BASE + 32'hC, 32'h0, "clrev_wr");
    chk_rd("clrev_ecnt", BASE + 32'hC, 32'h1);

    // Two pins rising together count once
    pins = 4'h0;
    ticks(8, "cnt_low");
    bus_write(BASE + 32'hC, 32'hDEAD, "cnt_clr");
    bus_write(BASE + 32'h4, 32'hF, "cnt_clrr");
    bus_write(BASE + 32'h8, 32'hF, "cnt_clrf");
    pins = 4'hA;
    ticks(6, "cnt_pair");
    chk_rd("pair_ecnt", BASE + 32'hC, 32'h1);
    chk_rd("pair_rise", BASE + 32'h4, 32'hA);
    chk_rd("pair_data", BASE, 32'hA);

    // Saturation
    pins = 4'h0;
    ticks(8, "sat_low");
    force dut.r_ecnt = 16'hFFFF;
    m_ecnt = 16'hFFFF;
    #1 release dut.r_ecnt;
    check_regs("sat_pre");
    pins = 4'h1;
    ticks(6, "sat_rise");
    chk_rd("sat_ecnt", BASE + 32'hC, 32'hFFFF);
    bus_write(BASE + 32'hC, 32'h1234, "sat_clr");
    chk_rd("sat_clr", BASE + 32'hC, 32'h0);

    // Decode and ignored writes
    chk_hit("hit_2000", 32'h2000, 1'b0);
    chk_rd("rd_2000", 32'h2000, 32'h0);
    chk_hit("hit_0ffc", 32'h0FFC, 1'b0);
    chk_hit("hit_1010", 32'h1010, 1'b0);
    chk_hit("hit_100f", 32'h100F, 1'b1);
    pins = 4'h3;
    ticks(6, "dec_rise");
    chk_rd("dec_ecnt", BASE + 32'hC, 32'h1);
    bus_write(32'h200C, 32'h0, "miss_wr");
    chk_rd("miss_ecnt", BASE + 32'hC, 32'h1);
    bus_write(32'h1014, 32'hF, "miss_wr2");
    bus_write(BASE, 32'h0, "data_wr");
    chk_rd("data_wr", BASE, 32'h3);

    // FALL register / disabled offset
    bus_write(BASE + 32'h8, 32'hF, "fall_clr");
    pins = 4'h1;
    ticks(6, "fall");
`ifdef GPIOIN_FALL_EDGE_EN
    chk_rd("fall_reg", BASE + 32'h8, 32'h2);
`else
    chk_rd("fall_off", BASE + 32'h8, 32'h0);
`endif

    // Reset mid-debounce discards the partial count
    pins = 4'h0;
    ticks(8, "mid_low");
    pins = 4'hF;
    ticks(3, "mid_part");
    rst_n = 1'b0;
    model_reset();
    chk_rd("mid_rst_data", BASE, 32'h0);
    tick();
    rst_n = 1'b1;
    ticks(5, "mid_rel");
    chk_rd("mid_data_c5", BASE, 32'h0);
    ticks(1, "mid_rel6");
    chk_rd("mid_data_c6", BASE, 32'hF);

    // Randomised pins and bus traffic against the model
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        pins = 4'($urandom);
        hold = $urandom_range(1, 7);
      end
      hold--;
      sel = $urandom_range(0, 9);
      if (sel < 8)       ra = BASE + 32'(4 * (sel % 4)) + 32'($urandom_range(0, 3));
      else if (sel == 8) ra = BASE + 32'h10;
      else               ra = $urandom;
      bus.addr  = ra;
      bus.wdata = $urandom;
      bus.we    = ($urandom_range(0, 3) == 0);
      #1;
      check("rnd_hit", {31'd0, bus.hit}, {31'd0, m_hit(ra)});
      check("rnd_rd", bus.rdata, m_read(ra));
      tick();
      bus.we = 1'b0;
      check_regs("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
